// File: rtl/up_down_counter_seq.sv
// rtl/up_down_counter_seq.sv - drives an up_down_counter to a target, dwells, then pulses done.
// Optional macro UDC_SHORTEST_PATH_EN picks the shorter modulo path; otherwise no wrap.
module up_down_counter_seq #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_target,
  input  logic [DWELL_W-1:0] req_dwell,
  input  logic               abort,
  input  logic [WIDTH-1:0]   count_in,
  output logic [1:0]         up_dwn,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, MOVE, DWELL, DONE} state_t;

  localparam logic [1:0] CODE_HOLD = 2'b00;
  localparam logic [1:0] CODE_UP   = 2'b01;
  localparam logic [1:0] CODE_DOWN = 2'b10;

  state_t             state, state_next;
  logic [WIDTH-1:0]   target;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [WIDTH:0]     steps;
  logic [WIDTH:0]     steps_inc;
  logic               dir_down;
  logic               dir_pick;
  logic               accept;
  logic               at_target;
  logic               timeout;

  assign accept    = req_valid && req_ready;
  assign at_target = (count_in == target);
  assign steps_inc = steps + 1'b1;

`ifdef UDC_SHORTEST_PATH_EN
  logic [WIDTH-1:0] dist_down;
  logic [WIDTH-1:0] dist_up;
  assign dist_down = count_in - req_target;
  assign dist_up   = req_target - count_in;
  // Strict compare sends the half-way tie upward.
  assign dir_pick  = (dist_down < dist_up);
`else
  assign dir_pick  = (req_target < count_in);
`endif

  always_comb begin
    state_next = state;
    up_dwn     = CODE_HOLD;
    timeout    = 1'b0;
    req_ready  = (state == IDLE);
    busy       = (state == MOVE) || (state == DWELL);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (accept) state_next = MOVE;
      end
      MOVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (at_target) begin
          state_next = DWELL;
        end else begin
          up_dwn = dir_down ? CODE_DOWN : CODE_UP;
          // A full lap of steps without arriving means the counter is not following.
          if (steps_inc[WIDTH]) begin
            timeout    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DWELL: begin
        if (abort) state_next = IDLE;
        else if (dwell_cnt <= DWELL_W'(1)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      target    <= '0;
      dwell_cnt <= '0;
      steps     <= '0;
      dir_down  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        target    <= req_target;
        dwell_cnt <= req_dwell;
        steps     <= '0;
        dir_down  <= dir_pick;
        err       <= 1'b0;
      end
      if (state == MOVE && up_dwn != CODE_HOLD) steps <= steps_inc;
      if (state == DWELL && dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_up_down_counter_seq.sv
// tb/tb_up_down_counter_seq.sv - directed bench for up_down_counter_seq with a plant counter.
module tb_up_down_counter_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_target;
  logic [3:0] req_dwell;
  logic       abort;
  logic [3:0] count_in;
  logic [1:0] up_dwn;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] cnt;
  logic       load_en;
  logic [3:0] load_val;
  logic       tie_en;
  logic [3:0] tie_val;

  int errors = 0;
  int checks = 0;

  up_down_counter_seq #(.WIDTH(4), .DWELL_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_dwell(req_dwell), .abort(abort),
    .count_in(count_in), .up_dwn(up_dwn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // The counter being steered.
  always @(posedge clk) begin
    if (load_en) cnt <= load_val;
    else begin
      case (up_dwn)
        2'b01: cnt <= cnt + 4'd1;
        2'b10: cnt <= cnt - 4'd1;
        2'b11: cnt <= 4'd0;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count_in = tie_en ? tie_val : cnt;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_cmd(input logic [3:0] c0, input logic [3:0] tgt, input logic [3:0] dw);
    load_en = 1'b1; load_val = c0;
    tick;
    load_en = 1'b0;
    chk("ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1; req_target = tgt; req_dwell = dw;
    tick;
    req_valid = 1'b0; req_target = ~tgt; req_dwell = 4'd9;
  endtask

  task automatic run_cmd(input logic [3:0] c0, input logic [3:0] tgt, input logic [3:0] dw,
                         input int nsteps, input logic [1:0] code);
    int total;
    total = nsteps + 1 + ((dw == 0) ? 1 : int'(dw)) + 1;
    accept_cmd(c0, tgt, dw);
    chk("err_cleared_on_accept", err, 1'b0);
    for (int i = 1; i <= total; i++) begin
      chk("up_dwn", up_dwn, (i <= nsteps) ? code : 2'b00);
      chk("done", done, (i == total) ? 1'b1 : 1'b0);
      chk("busy", busy, (i < total) ? 1'b1 : 1'b0);
      tick;
    end
    chk("count_final", cnt, tgt);
    chk("ready_after_done", req_ready, 1'b1);
    chk("done_cleared", done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_target = 4'd0; req_dwell = 4'd0; abort = 1'b0;
    load_en = 1'b0; load_val = 4'd0; tie_en = 1'b0; tie_val = 4'd0;
    tick;
    tick;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_up_dwn", up_dwn, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;

    // Reset mid-MOVE on 3 -> 9
    accept_cmd(4'd3, 4'd9, 4'd0);
    chk("midmove_up", up_dwn, 2'b01);
    chk("midmove_busy", busy, 1'b1);
    chk("midmove_ready", req_ready, 1'b0);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midrst_up_dwn", up_dwn, 2'b00);
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_err", err, 1'b0);

    run_cmd(4'd3, 4'd5, 4'd2, 2, 2'b01);
`ifdef UDC_SHORTEST_PATH_EN
    run_cmd(4'd14, 4'd1, 4'd0, 3, 2'b01);
    run_cmd(4'd2, 4'd12, 4'd1, 6, 2'b10);
    run_cmd(4'd0, 4'd8, 4'd0, 8, 2'b01);
`else
    run_cmd(4'd14, 4'd1, 4'd0, 13, 2'b10);
    run_cmd(4'd2, 4'd12, 4'd1, 10, 2'b01);
    run_cmd(4'd9, 4'd6, 4'd3, 3, 2'b10);
`endif
    run_cmd(4'd7, 4'd7, 4'd0, 0, 2'b00);

    // Abort while moving 0 -> 6 once two steps have landed
    accept_cmd(4'd0, 4'd6, 4'd0);
    chk("abort_step1", up_dwn, 2'b01);
    tick;
    chk("abort_step2", up_dwn, 2'b01);
    tick;
    abort = 1'b1;
    #1;
    chk("abort_same_cycle_hold", up_dwn, 2'b00);
    tick;
    abort = 1'b0;
    chk("abort_idle_ready", req_ready, 1'b1);
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_count", cnt, 4'd2);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", done, 1'b0);
      tick;
    end
    chk("abort_err_unchanged", err, 1'b0);

    // Stuck counter: watchdog trips after 16 up commands
    tie_en = 1'b1; tie_val = 4'd4;
    accept_cmd(4'd0, 4'd10, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      chk("stuck_up", up_dwn, 2'b01);
      chk("stuck_err_low", err, 1'b0);
      tick;
    end
    chk("stuck_err", err, 1'b1);
    chk("stuck_ready", req_ready, 1'b1);
    chk("stuck_busy", busy, 1'b0);
    chk("stuck_done", done, 1'b0);
    tick;
    chk("stuck_err_sticky", err, 1'b1);
    tie_en = 1'b0;
    run_cmd(4'd5, 4'd6, 4'd0, 1, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
